// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg
// Shared definitions for the UART frame router and its helpers:
//   - state_t   : frame parser states
//   - ERR_*     : err_code values reported with frame_err
//   - DEF_*     : default sync marker and command-range base
//   - is_cmd()  : true when a byte falls in the 16-byte command window
package uart_frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHAN    = 3'd1,
    S_LEN_HI  = 3'd2,
    S_LEN_LO  = 3'd3,
    S_PAYLOAD = 3'd4,
    S_CHECK   = 3'd5
  } state_t;

  localparam logic [1:0] ERR_BAD_CH   = 2'd0;
  localparam logic [1:0] ERR_BAD_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] DEF_CMD_BASE  = 8'hC0;

  // 9-bit compare so a base near 8'hFF does not wrap the window
  function automatic logic is_cmd(input logic [7:0] b, input logic [7:0] base);
    return ({1'b0, b} >= {1'b0, base}) && ({1'b0, b} <= ({1'b0, base} + 9'd15));
  endfunction

endpackage

// File: rtl/rx_idle_timer.sv
// rx_idle_timer
// Idle watchdog: a down-counter reloaded with CYCLES on i_clr and decremented
// while i_en is high. o_expire pulses for one cycle on the cycle whose clock
// edge completes CYCLES enabled, uncleared cycles. A clear on that same cycle
// suppresses the pulse.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (counter -> 0)
//   i_clr     : reload the counter (activity seen)
//   i_en      : count this cycle
//   o_expire  : one-cycle expiry strobe (combinational from the count)
module rx_idle_timer #(
  parameter int CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = $clog2(CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= CNT_W'(CYCLES);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expire = i_en && !i_clr && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/uart_frame_router.sv
// uart_frame_router
// Parses frames SYNC, CHAN, LEN_HI, LEN_LO, payload from a shared UART byte
// stream and steers payload bytes to one of NUM_CH one-hot channel strobes.
// Bytes in the command window seen while idle are forwarded on cmd_*.
// Optional build macro UART_FRAME_ROUTER_CHECKSUM_EN adds a trailing XOR
// checksum byte (over CHAN, LEN_HI, LEN_LO and payload) checked in S_CHECK.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   in_data, in_valid      : received byte and its one-cycle strobe
//   ch_enable              : per-channel accept mask, sampled at CHAN
//   out_data, out_valid    : payload byte, one-hot channel strobe
//   out_last               : with the final payload byte
//   cmd_data, cmd_valid    : idle command byte and strobe
//   frame_done, frame_err  : frame accepted / aborted pulses
//   err_code               : reason for the latest frame_err (held)
//   busy                   : parser is inside a frame
module uart_frame_router
  import uart_frame_pkg::*;
#(
  parameter int         NUM_CH         = 4,
  parameter int         LEN_W          = 16,
  parameter int         MAX_LEN        = 13128,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter logic [7:0] CMD_BASE       = DEF_CMD_BASE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic [7:0]        out_data,
  output logic [NUM_CH-1:0] out_valid,
  output logic              out_last,
  output logic [7:0]        cmd_data,
  output logic              cmd_valid,
  output logic              frame_done,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic              busy
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t            r_state, w_state_nxt;
  logic [CH_W-1:0]   r_ch, w_ch_nxt;
  logic [7:0]        r_len_hi, w_len_hi_nxt;
  logic [LEN_W-1:0]  r_rem, w_rem_nxt;
  logic [7:0]        r_out_data, w_out_data_nxt;
  logic [NUM_CH-1:0] r_out_valid, w_out_valid_nxt;
  logic              r_out_last, w_out_last_nxt;
  logic [7:0]        r_cmd_data, w_cmd_data_nxt;
  logic              r_cmd_valid, w_cmd_valid_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic [1:0]        r_err_code, w_err_code_nxt;
`ifdef UART_FRAME_ROUTER_CHECKSUM_EN
  logic [7:0]        r_ck, w_ck_nxt;
`endif

  logic [15:0]      w_len_raw;
  logic [LEN_W-1:0] w_len;
  logic             w_len_bad;
  logic             w_ch_ok;
  logic             w_expire;

  // Length is big-endian; upper bits beyond LEN_W are dropped
  assign w_len_raw = {r_len_hi, in_data};
  assign w_len     = LEN_W'(w_len_raw);
  assign w_len_bad = 32'(w_len) > 32'(MAX_LEN);
  // Range check guards the mask index for out-of-range ids
  assign w_ch_ok   = (32'(in_data) < 32'(NUM_CH)) && ch_enable[in_data[CH_W-1:0]];

  rx_idle_timer #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (in_valid),
    .i_en    (r_state != S_IDLE),
    .o_expire(w_expire)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_ch_nxt        = r_ch;
    w_len_hi_nxt    = r_len_hi;
    w_rem_nxt       = r_rem;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = '0;
    w_out_last_nxt  = 1'b0;
    w_cmd_data_nxt  = r_cmd_data;
    w_cmd_valid_nxt = 1'b0;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_err_code_nxt  = r_err_code;
`ifdef UART_FRAME_ROUTER_CHECKSUM_EN
    w_ck_nxt        = r_ck;
`endif
    if (in_valid) begin
      case (r_state)
        S_IDLE: begin
          if (in_data == SYNC_BYTE) begin
            w_state_nxt = S_CHAN;
`ifdef UART_FRAME_ROUTER_CHECKSUM_EN
            w_ck_nxt    = 8'h00;
`endif
          end else if (is_cmd(in_data, CMD_BASE)) begin
            w_cmd_data_nxt  = in_data;
            w_cmd_valid_nxt = 1'b1;
          end
        end
        S_CHAN: begin
          w_ch_nxt = in_data[CH_W-1:0];
`ifdef UART_FRAME_ROUTER_CHECKSUM_EN
          w_ck_nxt = in_data;
`endif
          if (w_ch_ok) begin
            w_state_nxt = S_LEN_HI;
          end else begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_BAD_CH;
            w_state_nxt    = S_IDLE;
          end
        end
        S_LEN_HI: begin
          w_len_hi_nxt = in_data;
`ifdef UART_FRAME_ROUTER_CHECKSUM_EN
          w_ck_nxt     = r_ck ^ in_data;
`endif
          w_state_nxt  = S_LEN_LO;
        end
        S_LEN_LO: begin
          w_rem_nxt = w_len;
`ifdef UART_FRAME_ROUTER_CHECKSUM_EN
          w_ck_nxt  = r_ck ^ in_data;
`endif
          if (w_len_bad) begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_BAD_LEN;
            w_state_nxt    = S_IDLE;
          end else if (w_len == '0) begin
`ifdef UART_FRAME_ROUTER_CHECKSUM_EN
            w_state_nxt = S_CHECK;
`else
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
`endif
          end else begin
            w_state_nxt = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          w_out_data_nxt        = in_data;
          w_out_valid_nxt[r_ch] = 1'b1;
          w_rem_nxt             = r_rem - LEN_W'(1);
`ifdef UART_FRAME_ROUTER_CHECKSUM_EN
          w_ck_nxt              = r_ck ^ in_data;
`endif
          if (r_rem == LEN_W'(1)) begin
            w_out_last_nxt = 1'b1;
`ifdef UART_FRAME_ROUTER_CHECKSUM_EN
            w_state_nxt    = S_CHECK;
`else
            w_done_nxt     = 1'b1;
            w_state_nxt    = S_IDLE;
`endif
          end
        end
`ifdef UART_FRAME_ROUTER_CHECKSUM_EN
        S_CHECK: begin
          if (in_data == r_ck) begin
            w_done_nxt = 1'b1;
          end else begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_CHECKSUM;
          end
          w_state_nxt = S_IDLE;
        end
`endif
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (w_expire) begin
      w_err_nxt      = 1'b1;
      w_err_code_nxt = ERR_TIMEOUT;
      w_state_nxt    = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ch        <= '0;
      r_len_hi    <= '0;
      r_rem       <= '0;
      r_out_data  <= '0;
      r_out_valid <= '0;
      r_out_last  <= 1'b0;
      r_cmd_data  <= '0;
      r_cmd_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= '0;
`ifdef UART_FRAME_ROUTER_CHECKSUM_EN
      r_ck        <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_ch        <= w_ch_nxt;
      r_len_hi    <= w_len_hi_nxt;
      r_rem       <= w_rem_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
      r_cmd_data  <= w_cmd_data_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_err_code  <= w_err_code_nxt;
`ifdef UART_FRAME_ROUTER_CHECKSUM_EN
      r_ck        <= w_ck_nxt;
`endif
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign cmd_data   = r_cmd_data;
  assign cmd_valid  = r_cmd_valid;
  assign frame_done = r_done;
  assign frame_err  = r_err;
  assign err_code   = r_err_code;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_frame_router.sv
// tb_uart_frame_router
// Scoreboard bench: each scenario pushes the strobes it expects, drives bytes,
// and a negedge monitor pops and compares every strobe the router produces.
module tb_uart_frame_router;
  import uart_frame_pkg::*;

  localparam int NUM_CH = 4;
  localparam int T      = 20;
  localparam int EV_DATA = 0, EV_CMD = 1, EV_DONE = 2, EV_ERR = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic [3:0]  ch_enable = 4'hF;
  logic [7:0]  out_data;
  logic [3:0]  out_valid;
  logic        out_last;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        frame_done;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;

  typedef struct {
    int         kind;
    logic [3:0] oh;
    logic [7:0] data;
    logic       last;
    logic [1:0] code;
  } ev_t;

  ev_t        sb[$];
  logic [7:0] pl[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  uart_frame_router #(
    .NUM_CH(NUM_CH), .LEN_W(16), .MAX_LEN(13128), .TIMEOUT_CYCLES(T),
    .SYNC_BYTE(8'hA5), .CMD_BASE(8'hC0)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .ch_enable(ch_enable), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code),
    .busy(busy)
  );

  task automatic push(input int kind, input int ch, input logic [7:0] d,
                      input logic last, input logic [1:0] code);
    ev_t e;
    e.kind = kind;
    e.oh   = (kind == EV_DATA) ? (4'b0001 << ch) : 4'b0000;
    e.data = d;
    e.last = last;
    e.code = code;
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Sends a well-formed frame carrying pl on channel ch and queues its strobes
  task automatic send_frame(input int ch);
    logic [7:0] ck;
    int n;
    n  = pl.size();
    ck = 8'(ch) ^ 8'(n >> 8) ^ 8'(n);
    for (int i = 0; i < n; i++) begin
      push(EV_DATA, ch, pl[i], (i == n - 1), 2'd0);
      ck = ck ^ pl[i];
    end
    push(EV_DONE, 0, 8'h00, 1'b0, 2'd0);
    send(8'hA5);
    send(8'(ch));
    send(8'(n >> 8));
    send(8'(n));
    for (int i = 0; i < n; i++) send(pl[i]);
`ifdef UART_FRAME_ROUTER_CHECKSUM_EN
    send(ck);
`endif
  endtask

  // Monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin : mon
    ev_t e;
    if (rst === 1'b0) begin
      if (out_valid !== 4'b0000) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL data_strobe: got valid=%b data=%h, nothing expected", out_valid, out_data);
        end else begin
          e = sb.pop_front();
          if (e.kind != EV_DATA || out_valid !== e.oh || out_data !== e.data || out_last !== e.last) begin
            n_fail++;
            $display("FAIL data_strobe: got valid=%b data=%h last=%b, want kind=%0d valid=%b data=%h last=%b",
                     out_valid, out_data, out_last, e.kind, e.oh, e.data, e.last);
          end
        end
      end else if (out_last !== 1'b0) begin
        n_tests++;
        n_fail++;
        $display("FAIL stray_last: got out_last=%b without out_valid, want 0", out_last);
      end
      if (cmd_valid !== 1'b0) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL cmd_strobe: got cmd=%h, nothing expected", cmd_data);
        end else begin
          e = sb.pop_front();
          if (e.kind != EV_CMD || cmd_data !== e.data) begin
            n_fail++;
            $display("FAIL cmd_strobe: got cmd=%h, want kind=%0d cmd=%h", cmd_data, e.kind, e.data);
          end
        end
      end
      if (frame_done !== 1'b0) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL done_strobe: got frame_done, nothing expected");
        end else begin
          e = sb.pop_front();
          if (e.kind != EV_DONE) begin
            n_fail++;
            $display("FAIL done_strobe: got frame_done, want kind=%0d", e.kind);
          end
        end
      end
      if (frame_err !== 1'b0) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL err_strobe: got frame_err code=%0d, nothing expected", err_code);
        end else begin
          e = sb.pop_front();
          if (e.kind != EV_ERR || err_code !== e.code) begin
            n_fail++;
            $display("FAIL err_strobe: got code=%0d, want kind=%0d code=%0d", err_code, e.kind, e.code);
          end
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({out_data, out_valid, out_last, cmd_data, cmd_valid, frame_done, frame_err, err_code, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h valid=%b last=%b cmd=%h cv=%b done=%b err=%b code=%0d busy=%b, want all 0",
               out_data, out_valid, out_last, cmd_data, cmd_valid, frame_done, frame_err, err_code, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got busy=%b err=%b, want 0 0", busy, frame_err);
    end
  endtask

  task automatic test_good_frame;
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(1);
    repeat (4) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL good_frame_drain: got %0d pending events, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_commands;
    logic [7:0] bytes [6];
    bytes = '{8'hC3, 8'h7F, 8'hC0, 8'hCF, 8'hBF, 8'hD0};
    push(EV_CMD, 0, 8'hC3, 1'b0, 2'd0);
    push(EV_CMD, 0, 8'hC0, 1'b0, 2'd0);
    push(EV_CMD, 0, 8'hCF, 1'b0, 2'd0);
    foreach (bytes[i]) send(bytes[i]);
    repeat (4) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL commands_drain: got %0d pending busy=%b, want 0 0", sb.size(), busy);
      sb.delete();
    end
  endtask

  task automatic test_sync_in_payload;
    pl = '{8'hC3, 8'hA5};
    send_frame(2);
    repeat (4) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sync_in_payload_drain: got %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_bad_len;
    push(EV_ERR, 0, 8'h00, 1'b0, ERR_BAD_LEN);
    send(8'hA5); send(8'h00); send(8'hFF); send(8'hFF);
    push(EV_ERR, 0, 8'h00, 1'b0, ERR_BAD_LEN);
    send(8'hA5); send(8'h00); send(8'h33); send(8'h49);
    repeat (4) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_len_drain: got %0d pending busy=%b, want 0 0", sb.size(), busy);
      sb.delete();
    end
  endtask

  task automatic test_zero_len;
    pl.delete();
    send_frame(0);
    repeat (4) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0 || err_code !== ERR_BAD_LEN) begin
      n_fail++;
      $display("FAIL zero_len: got %0d pending err_code=%0d, want 0 pending code=%0d",
               sb.size(), err_code, ERR_BAD_LEN);
      sb.delete();
    end
  endtask

  task automatic test_bad_channel;
    push(EV_ERR, 0, 8'h00, 1'b0, ERR_BAD_CH);
    send(8'hA5);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_ch_busy_after_sync: got %b, want 1", busy);
    end
    send(8'h05);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_ch_busy: got %b, want 0", busy);
    end
    ch_enable = 4'b1011;
    push(EV_ERR, 0, 8'h00, 1'b0, ERR_BAD_CH);
    send(8'hA5); send(8'h02);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL disabled_ch_busy: got %b, want 0", busy);
    end
    ch_enable = 4'hF;
    repeat (4) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL bad_ch_drain: got %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  // LEN = MAX_LEN is legal: the parser enters PAYLOAD and only the timeout ends it
  task automatic test_max_len;
    push(EV_ERR, 0, 8'h00, 1'b0, ERR_TIMEOUT);
    send(8'hA5); send(8'h00); send(8'h33); send(8'h48);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL max_len_busy: got %b, want 1", busy);
    end
    repeat (T + 4) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL max_len_drain: got %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_enable_sampled;
    logic [7:0] ck;
    ch_enable = 4'hF;
    push(EV_DATA, 3, 8'h5C, 1'b0, 2'd0);
    push(EV_DATA, 3, 8'h6D, 1'b1, 2'd0);
    push(EV_DONE, 0, 8'h00, 1'b0, 2'd0);
    send(8'hA5); send(8'h03);
    ch_enable = 4'h0;
    send(8'h00); send(8'h02); send(8'h5C); send(8'h6D);
    ck = 8'h03 ^ 8'h00 ^ 8'h02 ^ 8'h5C ^ 8'h6D;
`ifdef UART_FRAME_ROUTER_CHECKSUM_EN
    send(ck);
`endif
    ch_enable = 4'hF;
    repeat (4) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL enable_sampled_drain: got %0d pending (ck=%h), want 0", sb.size(), ck);
      sb.delete();
    end
  endtask

  task automatic test_timeout;
    push(EV_DATA, 0, 8'h11, 1'b0, 2'd0);
    push(EV_ERR, 0, 8'h00, 1'b0, ERR_TIMEOUT);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h02); send(8'h11);
    repeat (T) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 1) begin
      n_fail++;
      $display("FAIL timeout_early: got %0d pending one cycle before expiry, want 1", sb.size());
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0 || busy !== 1'b0 || err_code !== ERR_TIMEOUT) begin
      n_fail++;
      $display("FAIL timeout_fire: got pending=%0d busy=%b code=%0d, want 0 0 %0d",
               sb.size(), busy, err_code, ERR_TIMEOUT);
      sb.delete();
    end
  endtask

  task automatic test_timeout_race;
    logic [7:0] ck;
    push(EV_DATA, 0, 8'h11, 1'b0, 2'd0);
    push(EV_DATA, 0, 8'h22, 1'b1, 2'd0);
    push(EV_DONE, 0, 8'h00, 1'b0, 2'd0);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h02); send(8'h11);
    repeat (T - 1) @(posedge clk);
    #1;
    send(8'h22);
    ck = 8'h00 ^ 8'h00 ^ 8'h02 ^ 8'h11 ^ 8'h22;
`ifdef UART_FRAME_ROUTER_CHECKSUM_EN
    send(ck);
`endif
    repeat (4) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_race: got pending=%0d busy=%b (ck=%h), want 0 0", sb.size(), busy, ck);
      sb.delete();
    end
  endtask

`ifdef UART_FRAME_ROUTER_CHECKSUM_EN
  task automatic test_checksum;
    push(EV_DATA, 0, 8'h5A, 1'b1, 2'd0);
    push(EV_DONE, 0, 8'h00, 1'b0, 2'd0);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h01); send(8'h5A); send(8'h5B);
    push(EV_DATA, 0, 8'h5A, 1'b1, 2'd0);
    push(EV_ERR, 0, 8'h00, 1'b0, ERR_CHECKSUM);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h01); send(8'h5A); send(8'h00);
    repeat (4) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL checksum_drain: got %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask
`endif

  task automatic test_back_to_back;
    pl = '{8'hAA};
    send_frame(3);
    push(EV_CMD, 0, 8'hC5, 1'b0, 2'd0);
    send(8'hC5);
    pl = '{8'hC0, 8'h01};
    send_frame(0);
    repeat (4) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL back_to_back_drain: got %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_midframe;
    send(8'hA5); send(8'h01); send(8'h00);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midframe: got busy=%b err=%b, want 0 0", busy, frame_err);
    end
    repeat (T + 4) @(negedge clk);
    pl = '{8'h77};
    send_frame(1);
    repeat (4) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL reset_midframe_drain: got %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_commands();
    test_sync_in_payload();
    test_bad_len();
    test_zero_len();
    test_bad_channel();
    test_max_len();
    test_enable_sampled();
    test_timeout();
    test_timeout_race();
`ifdef UART_FRAME_ROUTER_CHECKSUM_EN
    test_checksum();
`endif
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_frame_router.md
Name: uart_frame_router

Overview:
- Parametrised successor to the fixed-protocol single-RX demux.
- Takes the byte stream from the one shared uart_rx and parses length-delimited frames: SYNC, CHAN, LEN_HI, LEN_LO, payload.
- Steers each payload to one of NUM_CH one-hot channel outputs, and forwards single-byte commands seen between frames.
- Adds what the fixed protocol lacks: explicit length, per-channel enable mask, inter-byte timeout and error reporting.

Parameters:
- NUM_CH, 4: number of payload channels; valid channel ids are 0..NUM_CH-1.
- LEN_W, 16: width of the length field and the payload counter.
- MAX_LEN, 13128: largest legal payload length; a larger LEN is an error.
- TIMEOUT_CYCLES, 1_000_000: idle clk cycles allowed between bytes inside a frame (10 ms at 100 MHz).
- SYNC_BYTE, 8'hA5: frame start marker.
- CMD_BASE, 8'hC0: idle bytes in CMD_BASE..CMD_BASE+15 are commands.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_data  in  8  byte from uart_rx
- in_valid  in  1  one-cycle strobe for in_data
- ch_enable  in  NUM_CH  per-channel accept mask
- out_data  out  8  payload byte
- out_valid  out  NUM_CH  one-hot strobe selecting the destination channel
- out_last  out  1  high with the final payload byte
- cmd_data  out  8  command byte
- cmd_valid  out  1  command strobe
- frame_done  out  1  pulse: frame accepted
- frame_err  out  1  pulse: frame aborted
- err_code  out  2  0 = bad channel, 1 = bad length, 2 = checksum, 3 = timeout; held until the next frame_err
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset: all outputs are 0; state is IDLE; counters and the checksum accumulator are 0. A reset mid-frame drops the frame silently and does not pulse frame_err.
- All outputs are registered. Strobes (out_valid, out_last, cmd_valid, frame_done, frame_err) are one-cycle pulses, issued one cycle after the in_valid that caused them. There is no backpressure.
- IDLE:
  - SYNC_BYTE goes to CHAN.
  - A byte in the command range gives cmd_data <= byte and cmd_valid.
  - Any other byte is ignored.
- CHAN: latch the id.
  - If id >= NUM_CH or ch_enable[id] = 0: frame_err with code 0, go to IDLE.
  - Otherwise go to LEN_HI.
- LEN_HI, then LEN_LO: assemble LEN big-endian; LEN_W bits, upper bits truncated.
  - LEN > MAX_LEN: frame_err with code 1, go to IDLE.
  - LEN = 0: frame_done, go to IDLE (or to CHECK under the option), with no out_valid.
  - Otherwise go to PAYLOAD.
- PAYLOAD:
  - Each byte drives out_valid[id] and out_data, and decrements the remaining count.
  - On the byte that brings the count to 0, out_last is also set; then frame_done and IDLE (or CHECK).
  - SYNC_BYTE and command-range bytes inside a payload are plain data.
- Timeout:
  - The counter is cleared on every in_valid and counts only when not IDLE.
  - Reaching TIMEOUT_CYCLES gives frame_err with code 3 and returns to IDLE.
  - If in_valid arrives on the same cycle as the timeout, the byte wins and the counter clears.
- ch_enable is sampled in CHAN only. Later changes do not affect a frame in progress.
- err_code is unchanged by successful frames.

Optional Feature:
- Macro: UART_FRAME_ROUTER_CHECKSUM_EN.
- Defined:
  - A CHECK state follows the payload, or follows LEN_LO when LEN = 0.
  - The accumulator is the XOR of the CHAN, LEN_HI, LEN_LO and all payload bytes.
  - The received byte equal to the accumulator gives frame_done; otherwise frame_err with code 2.
  - out_last still fires on the final payload byte. Consumers must discard the frame on frame_err.
  - The timeout also applies in CHECK.
- Undefined: no CHECK state and no accumulator logic; frame_done coincides with out_last.

Decomposition:
- Package uart_frame_pkg holds:
  - state encoding (IDLE, CHAN, LEN_HI, LEN_LO, PAYLOAD, CHECK);
  - err_code constants;
  - default SYNC_BYTE and CMD_BASE.
- One sub-module, rx_idle_timer: parametrised down-counter with clear/enable inputs and a one-cycle expire output. It is reusable by image_loader.

Test Plan:
- Good frame: A5 01 00 03 11 22 33 with ch_enable = 4'b1111 -> out_valid = 4'b0010 on 3 bytes with data 11, 22, 33; out_last on 33; frame_done on the same cycle.
- Idle bytes C3 then 7F -> a single cmd_valid with cmd_data = C3; 7F ignored. Payload A5 02 00 02 C3 A5 on channel 2 -> both bytes delivered as data.
- A5 05 ... with NUM_CH = 4 -> frame_err, err_code = 0, busy low next cycle. Repeat with A5 02 and ch_enable[2] = 0 -> same result.
- A5 00 FF FF -> frame_err with err_code = 1. A5 00 00 00 -> frame_done with no out_valid.
- A5 00 00 02 11, then silence for TIMEOUT_CYCLES -> frame_err with err_code = 3. Second case: in_valid arrives on the expiry cycle -> byte accepted, no error.
- With UART_FRAME_ROUTER_CHECKSUM_EN: A5 00 00 01 5A then checksum 5B (00^00^01^5A) -> frame_done. Same frame with checksum 00 -> frame_err with err_code = 2.
